// File: rtl/screen_vram_wr.sv
// screen_vram_wr
// Pixel packer and VRAM writer for the Z88 LCD. Each strobed character cell
// (one pixel byte, its attribute word and screen position) is decoded into
// 6 (lores) or 8 (hires) pixels and packed four pixels per 4-bit VRAM word.
//
// Ports
//   mck      master clock
//   rin      asynchronous active-high reset
//   lcdon    LCD enable; low clears the pipeline and blocks writes
//   pix_stb  one-cycle strobe qualifying pix/attr/slin/scol
//   pix      fetched pixel byte
//   attr     cell attribute word (13 hires, 12 reverse, 11 flash, 10 grey, 9 underline)
//   slin     screen pixel line 0..63
//   scol     character column; 0 marks the first cell of a line
//   vram_a   VRAM word address = slin*160 + x/4
//   vram_do  VRAM write data, bit 3 = leftmost pixel
//   vram_we  VRAM write enable, one cycle per word
//   ovf      sticky overflow, set when a strobe hits a busy stage 1
//
// Build option: define SCREEN_FLASH_EN to add the 5-bit frame counter that
// blanks attr[11] cells during the second half of a 32-frame period.
module screen_vram_wr (
    input  logic        mck,
    input  logic        rin,
    input  logic        lcdon,
    input  logic        pix_stb,
    input  logic [7:0]  pix,
    input  logic [13:0] attr,
    input  logic [5:0]  slin,
    input  logic [6:0]  scol,
    output logic [13:0] vram_a,
    output logic [3:0]  vram_do,
    output logic        vram_we,
    output logic        ovf
);
    localparam logic [9:0] LINE_PIXELS = 10'd640;

    // Stage 1: decoded cell, pixels left-aligned, unused low bits zero
    logic        s1_valid_reg;
    logic [7:0]  s1_px_reg;
    logic [3:0]  s1_cnt_reg;
    logic        s1_first_reg;
    logic [5:0]  s1_slin_reg;

    // Stage 2: pending accumulator, left-aligned at bit 10
    logic [10:0] acc_reg, acc_next;
    logic [3:0]  acc_cnt_reg, acc_cnt_next;
    logic [9:0]  x_reg, x_next;
    logic [5:0]  line_reg, line_next;

    logic [13:0] a_reg, a_next;
    logic [3:0]  do_reg, do_next;
    logic        we_reg, we_next;
    logic        ovf_reg;

    logic        accept;
    logic        s1_drain;
    logic [7:0]  cell_px;
    logic [3:0]  cell_cnt;
    logic        blank;

    assign accept = lcdon && pix_stb && !s1_valid_reg;

`ifdef SCREEN_FLASH_EN
    logic [4:0] frame_cnt_reg;
    logic [4:0] frame_now;
    logic       frame_bump;

    assign frame_bump = accept && (slin == 6'd0) && (scol == 7'd0);
    // The frame-start cell already belongs to the new frame.
    assign frame_now  = frame_bump ? frame_cnt_reg + 5'd1 : frame_cnt_reg;
    assign blank      = frame_now[4] && attr[11];

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            frame_cnt_reg <= 5'd0;
        end else if (frame_bump) begin
            frame_cnt_reg <= frame_now;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{attr[10], attr[8:0]};
`else
    assign blank = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{attr[11:10], attr[8:0]};
`endif

    // Cell decode: underline, then reverse, then flash blanking
    always_comb begin
        cell_px  = 8'h00;
        cell_cnt = 4'd6;
        if (attr[13]) begin
            cell_px  = pix;
            cell_cnt = 4'd8;
        end else if (attr[9] && (slin[2:0] == 3'd7)) begin
            cell_px  = 8'hFC;
        end else begin
            cell_px  = {pix[5:0], 2'b00};
        end
        if (attr[12]) begin
            cell_px = ~cell_px;
        end
        // Keep padding bits clear so they never OR into the accumulator.
        if (!attr[13]) begin
            cell_px = cell_px & 8'hFC;
        end
        if (blank) begin
            cell_px = 8'h00;
        end
    end

    // Stage 2: emit from the accumulator while it holds a full word,
    // otherwise merge stage 1 in and emit the first word of the merge.
    logic [3:0]  keep;
    logic [10:0] merged;
    logic [3:0]  merged_cnt;
    logic [10:0] src;
    logic [3:0]  src_cnt;
    logic [9:0]  x_cur;
    logic        take;

    always_comb begin
        keep         = s1_first_reg ? 4'd0 : acc_cnt_reg;
        merged       = (s1_first_reg ? 11'd0 : acc_reg) | ({s1_px_reg, 3'b000} >> keep);
        merged_cnt   = keep + s1_cnt_reg;
        src          = acc_reg;
        src_cnt      = acc_cnt_reg;
        x_cur        = x_reg;
        line_next    = line_reg;
        take         = 1'b0;
        s1_drain     = 1'b0;
        acc_next     = acc_reg;
        acc_cnt_next = acc_cnt_reg;
        x_next       = x_reg;
        a_next       = a_reg;
        do_next      = do_reg;
        we_next      = 1'b0;

        if (acc_cnt_reg >= 4'd4) begin
            take = 1'b1;
        end else if (s1_valid_reg) begin
            take      = 1'b1;
            s1_drain  = 1'b1;
            src       = merged;
            src_cnt   = merged_cnt;
            line_next = s1_slin_reg;
            if (s1_first_reg) begin
                x_cur = 10'd0;
            end
        end

        if (take) begin
            acc_next     = src << 4;
            acc_cnt_next = src_cnt - 4'd4;
            x_next       = x_cur;
            // Past the right edge the pixels are consumed but never written.
            if (x_cur < LINE_PIXELS) begin
                we_next = 1'b1;
                do_next = src[10:7];
                a_next  = {1'b0, line_next, 7'b0} + {3'b0, line_next, 5'b0}
                        + {6'b0, x_cur[9:2]};
                x_next  = x_cur + 10'd4;
            end
        end
    end

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            s1_valid_reg <= 1'b0;
            s1_px_reg    <= 8'h00;
            s1_cnt_reg   <= 4'd0;
            s1_first_reg <= 1'b0;
            s1_slin_reg  <= 6'd0;
            acc_reg      <= 11'd0;
            acc_cnt_reg  <= 4'd0;
            x_reg        <= 10'd0;
            line_reg     <= 6'd0;
            a_reg        <= 14'd0;
            do_reg       <= 4'd0;
            we_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
        end else if (!lcdon) begin
            s1_valid_reg <= 1'b0;
            acc_reg      <= 11'd0;
            acc_cnt_reg  <= 4'd0;
            we_reg       <= 1'b0;
        end else begin
            // A strobe while stage 1 is occupied is lost, even if that cell
            // is being merged in this same cycle.
            if (pix_stb && s1_valid_reg) begin
                ovf_reg <= 1'b1;
            end
            if (s1_drain) begin
                s1_valid_reg <= 1'b0;
            end
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_px_reg    <= cell_px;
                s1_cnt_reg   <= cell_cnt;
                s1_first_reg <= (scol == 7'd0);
                s1_slin_reg  <= slin;
            end
            acc_reg     <= acc_next;
            acc_cnt_reg <= acc_cnt_next;
            x_reg       <= x_next;
            line_reg    <= line_next;
            a_reg       <= a_next;
            do_reg      <= do_next;
            we_reg      <= we_next;
        end
    end

    assign vram_a  = a_reg;
    assign vram_do = do_reg;
    assign vram_we = we_reg;
    assign ovf     = ovf_reg;
endmodule

// File: tb/tb_screen_vram_wr.sv
// Testbench for screen_vram_wr: table of directed cells with hand-computed
// VRAM writes, plus sequences for the right edge, overflow, async reset
// during a burst, lcdon gating and (when built in) flash blanking.
module tb_screen_vram_wr;
    logic        mck = 1'b0;
    logic        rin = 1'b1;
    logic        lcdon = 1'b0;
    logic        pix_stb = 1'b0;
    logic [7:0]  pix = 8'h00;
    logic [13:0] attr = 14'h0000;
    logic [5:0]  slin = 6'd0;
    logic [6:0]  scol = 7'd0;
    logic [13:0] vram_a;
    logic [3:0]  vram_do;
    logic        vram_we;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    // write monitor
    int          mon_total = 0;
    int          mon_bad = 0;
    logic [13:0] mon_last = 14'd0;

    always #5 mck = ~mck;

    screen_vram_wr dut (
        .mck     (mck),
        .rin     (rin),
        .lcdon   (lcdon),
        .pix_stb (pix_stb),
        .pix     (pix),
        .attr    (attr),
        .slin    (slin),
        .scol    (scol),
        .vram_a  (vram_a),
        .vram_do (vram_do),
        .vram_we (vram_we),
        .ovf     (ovf)
    );

    always @(negedge mck) begin
        if (vram_we) begin
            mon_total <= mon_total + 1;
            mon_last  <= vram_a;
            if (vram_a > 14'd10239) mon_bad <= mon_bad + 1;
        end
    end

    typedef struct {
        logic [7:0]  pix;
        logic [13:0] attr;
        logic [5:0]  slin;
        logic [6:0]  scol;
        int          nw;
        logic [13:0] a0;
        logic [3:0]  d0;
        logic [13:0] a1;
        logic [3:0]  d1;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Strobe one cell; returns #1 after the capturing edge (cycle T+1).
    task automatic send_cell(input logic [7:0] p, input logic [13:0] at,
                             input logic [5:0] sl, input logic [6:0] sc);
        @(posedge mck); #1;
        pix = p; attr = at; slin = sl; scol = sc; pix_stb = 1'b1;
        @(posedge mck); #1;
        pix_stb = 1'b0;
    endtask

    task automatic cell_check(input string name, input logic [7:0] p, input logic [13:0] at,
                              input logic [5:0] sl, input logic [6:0] sc, input int nw,
                              input logic [13:0] a0, input logic [3:0] d0,
                              input logic [13:0] a1, input logic [3:0] d1);
        send_cell(p, at, sl, sc);
        chk({name, " we@T+1"}, 32'(vram_we), 32'd0);
        @(posedge mck); #1;
        chk({name, " we@T+2"}, 32'(vram_we), 32'(nw >= 1));
        if (nw >= 1) begin
            chk({name, " a0"}, 32'(vram_a), 32'(a0));
            chk({name, " d0"}, 32'(vram_do), 32'(d0));
        end
        @(posedge mck); #1;
        chk({name, " we@T+3"}, 32'(vram_we), 32'(nw == 2));
        if (nw == 2) begin
            chk({name, " a1"}, 32'(vram_a), 32'(a1));
            chk({name, " d1"}, 32'(vram_do), 32'(d1));
        end
        @(posedge mck); #1;
        chk({name, " we@T+4"}, 32'(vram_we), 32'd0);
        $display("[TB] %s pix=%h attr=%h slin=%0d scol=%0d writes=%0d", name, p, at, sl, sc, nw);
    endtask

    task automatic pulse_reset();
        @(posedge mck); #1;
        rin = 1'b1;
        @(posedge mck); #1;
        rin = 1'b0;
    endtask

    initial begin
        int snap;
        logic [3:0] e;

        //            pix    attr      slin scol nw a0     d0    a1     d1
        vecs[0]  = '{8'hA5, 14'h2000, 6'd0,  7'd0, 2, 14'd0,    4'hA, 14'd1,    4'h5};
        vecs[1]  = '{8'h3F, 14'h0000, 6'd1,  7'd0, 1, 14'd160,  4'hF, 14'd0,    4'h0};
        vecs[2]  = '{8'h3F, 14'h0000, 6'd1,  7'd1, 2, 14'd161,  4'hF, 14'd162,  4'hF};
        vecs[3]  = '{8'h00, 14'h1200, 6'd7,  7'd0, 1, 14'd1120, 4'h0, 14'd0,    4'h0};
        vecs[4]  = '{8'h00, 14'h1200, 6'd6,  7'd0, 1, 14'd960,  4'hF, 14'd0,    4'h0};
        vecs[5]  = '{8'h3C, 14'h2000, 6'd2,  7'd0, 2, 14'd320,  4'h3, 14'd321,  4'hC};
        vecs[6]  = '{8'h0F, 14'h3000, 6'd2,  7'd1, 2, 14'd322,  4'hF, 14'd323,  4'h0};
        vecs[7]  = '{8'h81, 14'h2200, 6'd7,  7'd0, 2, 14'd1120, 4'h8, 14'd1121, 4'h1};
        vecs[8]  = '{8'h00, 14'h0200, 6'd15, 7'd0, 1, 14'd2400, 4'hF, 14'd0,    4'h0};
        vecs[9]  = '{8'hE1, 14'h0000, 6'd15, 7'd1, 2, 14'd2401, 4'hE, 14'd2402, 4'h1};
        vecs[10] = '{8'h3F, 14'h0400, 6'd3,  7'd0, 1, 14'd480,  4'hF, 14'd0,    4'h0};
        vecs[11] = '{8'h3F, 14'h0800, 6'd3,  7'd1, 2, 14'd481,  4'hF, 14'd482,  4'hF};
        vecs[12] = '{8'h3F, 14'h0000, 6'd4,  7'd0, 1, 14'd640,  4'hF, 14'd0,    4'h0};
        vecs[13] = '{8'h00, 14'h2000, 6'd4,  7'd0, 2, 14'd640,  4'h0, 14'd641,  4'h0};

        // reset state
        repeat (3) @(posedge mck);
        #1;
        chk("reset we", 32'(vram_we), 32'd0);
        chk("reset a", 32'(vram_a), 32'd0);
        chk("reset do", 32'(vram_do), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        rin = 1'b0;
        lcdon = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cell_check($sformatf("vec%0d", i), vecs[i].pix, vecs[i].attr, vecs[i].slin,
                       vecs[i].scol, vecs[i].nw, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
        end

        // right edge: 108 lores cells on line 63 -> 160 writes, last 10239
        snap = mon_total;
        for (int c = 0; c < 108; c++) begin
            send_cell(8'h3F, 14'h0000, 6'd63, 7'(c));
            @(posedge mck);
        end
        repeat (6) @(posedge mck);
        #1;
        chk("edge writes", 32'(mon_total - snap), 32'd160);
        chk("edge last a", 32'(mon_last), 32'd10239);
        chk("edge no a>10239", 32'(mon_bad), 32'd0);
        $display("[TB] right edge: %0d writes, last a=%0d", mon_total - snap, mon_last);
        cell_check("new frame", 8'hFF, 14'h2000, 6'd0, 7'd0, 2, 14'd0, 4'hF, 14'd1, 4'hF);

        // overflow: back-to-back strobes, second lost
        chk("ovf before", 32'(ovf), 32'd0);
        snap = mon_total;
        @(posedge mck); #1;
        pix = 8'hFF; attr = 14'h2000; slin = 6'd5; scol = 7'd0; pix_stb = 1'b1;
        @(posedge mck); #1;
        pix = 8'h00; scol = 7'd1;
        @(posedge mck); #1;
        pix_stb = 1'b0;
        repeat (5) @(posedge mck);
        #1;
        chk("ovf set", 32'(ovf), 32'd1);
        chk("ovf writes", 32'(mon_total - snap), 32'd2);
        chk("ovf last a", 32'(mon_last), 32'd801);
        $display("[TB] overflow: ovf=%0d writes=%0d", ovf, mon_total - snap);
        cell_check("after ovf", 8'h0F, 14'h2000, 6'd5, 7'd0, 2, 14'd800, 4'h0, 14'd801, 4'hF);
        chk("ovf held", 32'(ovf), 32'd1);
        pulse_reset();
        chk("ovf cleared", 32'(ovf), 32'd0);

        // reset asserted mid-burst
        send_cell(8'hF0, 14'h2000, 6'd9, 7'd0);
        @(posedge mck); #1;
        chk("burst we@T+2", 32'(vram_we), 32'd1);
        #2;
        rin = 1'b1;
        #1;
        chk("async we drop", 32'(vram_we), 32'd0);
        chk("async a clear", 32'(vram_a), 32'd0);
        @(posedge mck); #1;
        rin = 1'b0;
        snap = mon_total;
        repeat (4) @(posedge mck);
        #1;
        chk("burst aborted", 32'(mon_total - snap), 32'd0);
        $display("[TB] reset mid-burst: we after reset writes=%0d", mon_total - snap);

        // lcdon low: strobe ignored
        lcdon = 1'b0;
        cell_check("lcdon low", 8'hFF, 14'h2000, 6'd0, 7'd5, 0, 14'd0, 4'h0, 14'd0, 4'h0);
        lcdon = 1'b1;

        // flash across 32 frames
        pulse_reset();
        for (int i = 1; i <= 32; i++) begin
            if (i == 8) begin
                // frame counter must hold while lcdon is low
                lcdon = 1'b0;
                send_cell(8'hFF, 14'h2800, 6'd0, 7'd0);
                lcdon = 1'b1;
            end
`ifdef SCREEN_FLASH_EN
            e = (i >= 16 && i <= 31) ? 4'h0 : 4'hF;
`else
            e = 4'hF;
`endif
            cell_check($sformatf("frame%0d", i), 8'hFF, 14'h2800, 6'd0, 7'd0, 2,
                       14'd0, e, 14'd1, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
